// File: rtl/cpu_types.sv
// Shared OTTER out-of-order core types, including the reservation-station
// entry layout used by rs_bank.
package cpu_types;

  localparam int CPU_XLEN = 32;

  typedef logic [5:0]          RS_tag_type;
  typedef logic [CPU_XLEN-1:0] word_t;

  localparam RS_tag_type INVALID = '0;

  typedef struct packed {
    logic [3:0] alu_fun;
    logic [2:0] mem_type;
  } task_t;

  typedef struct packed {
    RS_tag_type tag;
    word_t      data;
  } cdb_t;

  typedef enum logic [1:0] {FREE, WAIT, READY, ISSUED} rs_state_t;

  typedef struct packed {
    word_t      value;
    RS_tag_type tag;
    logic       pending;
  } rs_operand_t;

  typedef struct packed {
    rs_state_t         state;
    task_t             task_info;
    rs_operand_t [2:0] op;
  } rs_entry_t;

endpackage

// File: rtl/rs_bank_age_select.sv
// Age matrix and oldest-ready one-hot picker for the reservation station.
// older[i][j] set means entry j was dispatched before entry i.
module rs_age_select #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] busy,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0] older [DEPTH];

  // Clearing column i on reallocation removes stale "older" bits left behind
  // by a previous occupant of entry i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < DEPTH; r++) older[r] <= '0;
    end else if (flush) begin
      for (int unsigned r = 0; r < DEPTH; r++) older[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (alloc[r]) older[r] <= busy;
        else          older[r] <= older[r] & ~alloc;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      grant[i] = ready[i] && ((older[i] & ready) == '0);
  end

endmodule

// File: rtl/rs_bank.sv
// Multi-entry reservation station: captures operands from the CDB and
// issues the oldest ready task to its functional unit.
module rs_bank
  import cpu_types::*;
#(
  parameter int DEPTH    = 4,
  parameter int TAG_BASE = 1,
  parameter int XLEN     = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  task_t                    dispatch_task,
  input  RS_tag_type               T1,
  input  RS_tag_type               T2,
  input  RS_tag_type               T3,
  input  logic [XLEN-1:0]          A,
  input  logic [XLEN-1:0]          B,
  input  logic [XLEN-1:0]          rs2_data,
  input  cdb_t                     cdb_in,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [XLEN-1:0]          V1,
  output logic [XLEN-1:0]          V2,
  output logic [XLEN-1:0]          V3,
  output RS_tag_type               rd_tag,
  output logic [3:0]               alu_fun,
  output logic [2:0]               mem_type,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     empty
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCCW = $clog2(DEPTH) + 1;

  rs_entry_t        ent     [DEPTH];
  rs_entry_t        ent_nxt [DEPTH];
  rs_entry_t        new_ent;
  logic [DEPTH-1:0] free_mask, busy_mask, ready_mask, alloc_oh, alloc_en, grant;
  logic [IDXW-1:0]  sel_idx;
  logic             do_dispatch, cdb_hit, found;
  word_t            din [3];
  RS_tag_type       tin [3];

  always_comb begin
    free_mask  = '0;
    ready_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      free_mask[i]  = (ent[i].state == FREE);
      ready_mask[i] = (ent[i].state == READY);
    end
  end

  assign busy_mask      = ~free_mask;
  assign dispatch_ready = |free_mask;
  assign empty          = &free_mask;
  assign do_dispatch    = dispatch_valid && dispatch_ready && !flush;
  assign alloc_en       = alloc_oh & {DEPTH{do_dispatch}};
  assign cdb_hit        = (cdb_in.tag != INVALID);

  always_comb begin
    alloc_oh  = '0;
    found     = 1'b0;
    occupancy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (free_mask[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
      if (busy_mask[i]) occupancy = occupancy + OCCW'(1);
    end
  end

  // Operand resolution at dispatch: present value, same-cycle CDB bypass, or pending tag.
  always_comb begin
    din[0] = word_t'(A);
    din[1] = word_t'(B);
    din[2] = word_t'(rs2_data);
    tin[0] = T1;
    tin[1] = T2;
    tin[2] = T3;
    new_ent           = '0;
    new_ent.state     = READY;
    new_ent.task_info = dispatch_task;
    for (int unsigned k = 0; k < 3; k++) begin
      if (tin[k] == INVALID) begin
        new_ent.op[k].value = din[k];
      end else if (cdb_hit && tin[k] == cdb_in.tag) begin
        new_ent.op[k].value = cdb_in.data;
      end else begin
        new_ent.op[k].tag     = tin[k];
        new_ent.op[k].pending = 1'b1;
        new_ent.state         = WAIT;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_nxt[i] = ent[i];
      if (flush) begin
        ent_nxt[i] = '0;
      end else begin
        case (ent[i].state)
          FREE: if (alloc_en[i]) ent_nxt[i] = new_ent;
          WAIT: begin
            for (int unsigned k = 0; k < 3; k++) begin
              if (ent[i].op[k].pending && cdb_hit && ent[i].op[k].tag == cdb_in.tag) begin
                ent_nxt[i].op[k].value   = cdb_in.data;
                ent_nxt[i].op[k].pending = 1'b0;
              end
            end
            if (!(ent_nxt[i].op[0].pending || ent_nxt[i].op[1].pending ||
                  ent_nxt[i].op[2].pending))
              ent_nxt[i].state = READY;
          end
          READY:  if (grant[i] && issue_ready) ent_nxt[i].state = ISSUED;
          ISSUED: if (cdb_hit && cdb_in.tag == RS_tag_type'(TAG_BASE + i)) ent_nxt[i] = '0;
          default: ent_nxt[i] = ent[i];
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
    end
  end

  rs_age_select #(.DEPTH(DEPTH)) u_age (
    .clk   (CLK),
    .rst   (RST),
    .flush (flush),
    .alloc (alloc_en),
    .busy  (busy_mask),
    .ready (ready_mask),
    .grant (grant)
  );

  assign issue_valid = |grant;

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (grant[i]) sel_idx = IDXW'(i);
  end

  always_comb begin
    V1       = '0;
    V2       = '0;
    V3       = '0;
    rd_tag   = INVALID;
    alu_fun  = '0;
    mem_type = '0;
    if (issue_valid) begin
      V1       = XLEN'(ent[sel_idx].op[0].value);
      V2       = XLEN'(ent[sel_idx].op[1].value);
      V3       = XLEN'(ent[sel_idx].op[2].value);
      rd_tag   = RS_tag_type'(TAG_BASE + int'(sel_idx));
      alu_fun  = ent[sel_idx].task_info.alu_fun;
      mem_type = ent[sel_idx].task_info.mem_type;
    end
  end

endmodule

// File: tb/tb_rs_bank.sv
// Directed self-checking bench for rs_bank with DEPTH=4, TAG_BASE=1.
module tb_rs_bank;
  import cpu_types::*;

  localparam int DEPTH    = 4;
  localparam int TAG_BASE = 1;
  localparam int XLEN     = 32;

  logic                   CLK, RST, flush, dispatch_valid, dispatch_ready;
  task_t                  dispatch_task;
  RS_tag_type             T1, T2, T3, rd_tag;
  logic [XLEN-1:0]        A, B, rs2_data, V1, V2, V3;
  cdb_t                   cdb_in;
  logic                   issue_valid, issue_ready, empty;
  logic [3:0]             alu_fun;
  logic [2:0]             mem_type;
  logic [$clog2(DEPTH):0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  rs_bank #(.DEPTH(DEPTH), .TAG_BASE(TAG_BASE), .XLEN(XLEN)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_task(dispatch_task), .T1(T1), .T2(T2), .T3(T3),
    .A(A), .B(B), .rs2_data(rs2_data), .cdb_in(cdb_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .V1(V1), .V2(V2), .V3(V3), .rd_tag(rd_tag),
    .alu_fun(alu_fun), .mem_type(mem_type),
    .occupancy(occupancy), .empty(empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input RS_tag_type t1, input RS_tag_type t2, input RS_tag_type t3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [3:0] fun, input logic [2:0] mt);
    T1 = t1; T2 = t2; T3 = t3;
    A = a; B = b; rs2_data = c;
    dispatch_task.alu_fun  = fun;
    dispatch_task.mem_type = mt;
    dispatch_valid = 1'b1;
  endtask

  task automatic broadcast(input RS_tag_type t, input logic [31:0] d);
    cdb_in.tag  = t;
    cdb_in.data = d;
  endtask

  task automatic free_tag(input RS_tag_type t);
    broadcast(t, 32'hDEAD_0000);
    tick;
    broadcast(INVALID, '0);
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; issue_ready = 1'b0;
    dispatch_task = '0; T1 = INVALID; T2 = INVALID; T3 = INVALID;
    A = '0; B = '0; rs2_data = '0;
    broadcast(INVALID, '0);
    #12;
    check("rst_dispatch_ready", dispatch_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_occupancy", occupancy, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_rd_tag", rd_tag, 0);
    check("rst_v1", V1, 0);
    RST = 1'b0;

    // Ready dispatch
    issue_ready = 1'b1;
    offer(INVALID, INVALID, INVALID, 5, 7, 3, 4'h3, 3'h2);
    tick;
    dispatch_valid = 1'b0;
    check("rdy_issue_valid", issue_valid, 1);
    check("rdy_v1", V1, 5);
    check("rdy_v2", V2, 7);
    check("rdy_v3", V3, 3);
    check("rdy_rd_tag", rd_tag, TAG_BASE);
    check("rdy_alu_fun", alu_fun, 4'h3);
    check("rdy_mem_type", mem_type, 3'h2);
    check("rdy_occupancy", occupancy, 1);
    tick;
    check("issued_not_valid", issue_valid, 0);
    check("issued_still_held", occupancy, 1);
    free_tag(1);
    check("rdy_freed_empty", empty, 1);

    // CDB capture
    offer(9, INVALID, INVALID, 32'h1111, 8, 0, 4'h1, 3'h0);
    tick;
    dispatch_valid = 1'b0;
    check("cap_waiting", issue_valid, 0);
    check("cap_occupancy", occupancy, 1);
    broadcast(9, 32'h42);
    tick;
    broadcast(INVALID, '0);
    check("cap_issue_valid", issue_valid, 1);
    check("cap_v1", V1, 32'h42);
    check("cap_v2", V2, 8);
    check("cap_rd_tag", rd_tag, 1);
    tick;
    free_tag(1);
    check("cap_freed_empty", empty, 1);

    // Same-cycle bypass
    offer(9, INVALID, INVALID, 32'h1111, 6, 0, 4'h2, 3'h1);
    broadcast(9, 32'h55);
    tick;
    dispatch_valid = 1'b0;
    broadcast(INVALID, '0);
    check("byp_issue_valid", issue_valid, 1);
    check("byp_v1", V1, 32'h55);
    check("byp_v2", V2, 6);
    tick;
    free_tag(1);
    check("byp_freed_empty", empty, 1);

    // Oldest-first
    issue_ready = 1'b0;
    offer(9, INVALID, INVALID, 0, 32'h11, 0, 4'h1, 3'h0);
    tick;
    offer(INVALID, INVALID, INVALID, 32'h22, 32'h33, 0, 4'h2, 3'h0);
    tick;
    dispatch_valid = 1'b0;
    check("age_y_presented", rd_tag, 2);
    broadcast(9, 32'h99);
    tick;
    broadcast(INVALID, '0);
    check("age_x_preempts", rd_tag, 1);
    check("age_x_v1", V1, 32'h99);
    check("age_x_fun", alu_fun, 4'h1);
    issue_ready = 1'b1;
    tick;
    check("age_y_next_valid", issue_valid, 1);
    check("age_y_next_tag", rd_tag, 2);
    check("age_y_next_v1", V1, 32'h22);
    tick;
    check("age_all_issued", issue_valid, 0);
    free_tag(1);
    free_tag(2);
    check("age_freed_empty", empty, 1);

    // Full
    for (int i = 0; i < DEPTH; i++) begin
      offer(INVALID, INVALID, INVALID, 32'(i + 1), 0, 0, 4'h5, 3'h0);
      tick;
    end
    check("full_ready_low", dispatch_ready, 0);
    check("full_occupancy", occupancy, 4);
    check("full_last_tag", rd_tag, 4);
    check("full_last_v1", V1, 4);
    offer(INVALID, INVALID, INVALID, 32'h55, 0, 0, 4'h6, 3'h0);
    tick;
    dispatch_valid = 1'b0;
    check("full_fifth_occ", occupancy, 4);
    check("full_fifth_no_issue", issue_valid, 0);
    free_tag(1);
    check("full_ready_back", dispatch_ready, 1);
    check("full_occ_after_free", occupancy, 3);
    free_tag(2);
    free_tag(3);
    free_tag(4);
    check("full_drained_empty", empty, 1);

    // Flush with concurrent dispatch
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(INVALID, INVALID, INVALID, 32'(16 + i), 0, 0, 4'h7, 3'h0);
      tick;
    end
    check("flush_pre_occ", occupancy, 3);
    check("flush_pre_oldest", rd_tag, 1);
    offer(INVALID, INVALID, INVALID, 32'h66, 0, 0, 4'h8, 3'h0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    dispatch_valid = 1'b0;
    check("flush_occ", occupancy, 0);
    check("flush_empty", empty, 1);
    check("flush_no_issue", issue_valid, 0);
    offer(INVALID, INVALID, INVALID, 32'h77, 0, 0, 4'h9, 3'h0);
    tick;
    dispatch_valid = 1'b0;
    check("post_flush_tag", rd_tag, 1);
    check("post_flush_v1", V1, 32'h77);
    check("post_flush_occ", occupancy, 1);

    // Asynchronous reset mid-capture
    offer(9, INVALID, INVALID, 0, 0, 0, 4'h1, 3'h0);
    tick;
    dispatch_valid = 1'b0;
    check("arst_pre_occ", occupancy, 2);
    broadcast(9, 32'hABC);
    #2;
    RST = 1'b1;
    #1;
    check("arst_issue_valid", issue_valid, 0);
    check("arst_dispatch_ready", dispatch_ready, 1);
    check("arst_occupancy", occupancy, 0);
    check("arst_empty", empty, 1);
    check("arst_rd_tag", rd_tag, 0);
    check("arst_v1", V1, 0);
    tick;
    check("arst_held_empty", empty, 1);
    RST = 1'b0;
    broadcast(INVALID, '0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_bank.md
# rs_bank

Multi-entry, parametrised reservation station for the out-of-order OTTER core. It sits between dispatch and one functional unit (ALU, load, or store). It holds up to `DEPTH` in-flight tasks and captures missing operands from the CDB. Each cycle it issues the oldest task whose operands are all ready. An entry's tag is the tag of its result, so the entry stays allocated until that result appears on the CDB.

## Interface

Parameters:
- `DEPTH`, 4: number of entries; power of two, 2–16.
- `TAG_BASE`, 1: tag of entry 0. Entry i owns tag `TAG_BASE+i`. No entry tag may equal `INVALID`.
- `XLEN`, 32: operand width.

Ports:
- `CLK` in 1: the single clock.
- `RST` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of all entries.
- `dispatch_valid` in 1: dispatch offers a task.
- `dispatch_ready` out 1: at least one entry is FREE.
- `dispatch_task` in `task_t`: task, providing `alu_fun` and `mem_type`.
- `T1`, `T2`, `T3` in `RS_tag_type`: map-table tags; `INVALID` means the value is present.
- `A`, `B`, `rs2_data` in XLEN: operand values, used when the matching tag is `INVALID`.
- `cdb_in` in `cdb_t`: CDB broadcast; it is valid when `cdb_in.tag != INVALID`.
- `issue_valid` out 1: a ready entry is presented.
- `issue_ready` in 1: the FU accepts the presented entry.
- `V1`, `V2`, `V3` out XLEN: operands of the presented entry.
- `rd_tag` out `RS_tag_type`: tag of the presented entry.
- `alu_fun` out 4: function code of the presented entry.
- `mem_type` out 3: memory type of the presented entry.
- `occupancy` out clog2(DEPTH)+1: number of non-FREE entries.
- `empty` out 1: all entries are FREE.

## Operation

- **Entry states:**
  - FREE → WAIT on dispatch with a pending operand.
  - FREE → READY on dispatch with all operands present.
  - WAIT → READY when the last pending operand is captured.
  - READY → ISSUED on an issue handshake.
  - ISSUED → FREE when `cdb_in.tag` equals the entry's tag.
- **Dispatch:** accepted when `dispatch_valid && dispatch_ready`. The task goes into the lowest-index FREE entry, evaluated on current-cycle state. An entry freed in cycle n cannot be allocated until n+1.
- **Operand k at dispatch:**
  - If Tk == `INVALID`, latch the supplied value.
  - Else if Tk == `cdb_in.tag`, latch `cdb_in.data` (same-cycle bypass).
  - Otherwise store Tk as pending.
- **CDB snoop:** every WAIT entry compares each pending tag with `cdb_in.tag`. On a match it latches the data and clears pending. Multiple entries and multiple operands may capture in the same cycle.
- **Issue select:** among READY entries, pick the oldest by dispatch order.
  - Age is tracked by a DEPTH×DEPTH age matrix. On allocation of entry i, row i is set to "older than i" for every non-FREE entry.
  - Outputs show the selected entry combinationally from its registers.
  - The transfer happens when `issue_valid && issue_ready`.
  - While `issue_ready` is low, the selected entry stays READY. A newly readied, older entry may pre-empt it in the next cycle; the FU must not assume a stable selection until it accepts.
- **flush:** all entries go FREE in the next cycle and dispatch is ignored that cycle. `flush` has priority over every other event.
- **`RST`:** all entries FREE, age matrix 0. Outputs: `dispatch_ready`=1, `empty`=1, `occupancy`=0, `issue_valid`=0, data outputs 0, `rd_tag`=`INVALID`.

## Timing

- Dispatch to `issue_valid`: 1 cycle when all operands are present or bypassed at dispatch.
- CDB capture to `issue_valid`: 1 cycle.
- The issue handshake at edge n moves the entry to ISSUED. The next-oldest READY entry is presented in cycle n+1.
- An entry cannot be freed by a CDB broadcast until after it has issued.
- `dispatch_ready`, `empty`, and `occupancy` are derived only from registered state; no combinational path from `dispatch_valid`.
- When full, `dispatch_ready`=0 and a dispatch offer is ignored without side effects.

## Structure

- The shared package `cpu_types` holds:
  - existing `task_t`, `cdb_t`, `RS_tag_type`, `INVALID`;
  - new `rs_state_t` enum {FREE, WAIT, READY, ISSUED};
  - new `rs_entry_t` struct: state, `task_t`, 3× {value, tag, pending}.
- Sub-module `rs_age_select`: age matrix plus the oldest-ready one-hot picker, parametrised by `DEPTH`.

## Test plan

- **Ready dispatch:** reset, then dispatch T1=T2=T3=`INVALID`, A=5, B=7, `issue_ready`=1 → next cycle `issue_valid`=1, V1=5, V2=7, `rd_tag`=TAG_BASE. A CDB broadcast of TAG_BASE then frees the entry, `empty`=1.
- **CDB capture and bypass:**
  - Dispatch T1=9 → entry sits in WAIT. `cdb_in`={9, 0x42} → issue the next cycle with V1=0x42.
  - Repeat with the CDB broadcasting tag 9 in the dispatch cycle itself → same result via bypass.
- **Oldest-first:**
  - Dispatch task X waiting on tag 9, then task Y all-ready. Hold `issue_ready`=0.
  - Broadcast tag 9 → X is presented ahead of Y.
  - Raise `issue_ready` → X accepted first, Y presented the next cycle.
- **Full:** with `DEPTH`=4, four dispatches without CDB → `dispatch_ready`=0 and `occupancy`=4. A fifth offer is ignored. A CDB broadcast of an issued tag raises `dispatch_ready` in the next cycle.
- **flush and reset:**
  - `flush` with 3 occupied entries and a dispatch in the same cycle → all FREE, dispatch dropped.
  - Assert `RST` asynchronously mid-capture → outputs at reset values immediately.
